// File: rtl/gen_scheduler_if.sv
// Handshake bundle between the sample scheduler, its two value generators and the downstream consumer.
// master = scheduler side; slave = generators, consumer and control logic.
interface gen_scheduler_if;
    logic        run;
    logic [1:0]  mode;
    logic        err_clr;
    logic        en0;
    logic        valid0;
    logic [15:0] data0;
    logic        en1;
    logic        valid1;
    logic [15:0] data1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_src;
    logic        busy;
    logic [15:0] sample_cnt;
    logic        err_timeout;
    logic        err_overrun;

    modport master (
        input  run, mode, err_clr, valid0, data0, valid1, data1, out_ready,
        output en0, en1, out_valid, out_data, out_src, busy, sample_cnt,
               err_timeout, err_overrun
    );

    modport slave (
        output run, mode, err_clr, valid0, data0, valid1, data1, out_ready,
        input  en0, en1, out_valid, out_data, out_src, busy, sample_cnt,
               err_timeout, err_overrun
    );
endinterface

// File: rtl/gen_scheduler.sv
// Tick-paced request/capture sequencer for two 16-bit generators; one output per tick slot.
// Capture appears one cycle after valid; out_valid holds data stable until out_ready.
module gen_scheduler #(
    parameter int TICK_DIV = 5000000,
    parameter int TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    gen_scheduler_if.master io_bus
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int OW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]    r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [OW-1:0] r_to_cnt;
    logic          r_sel;
    logic          r_rr;
    logic [15:0]   r_out_data;
    logic          r_out_src;
    logic [15:0]   r_sample_cnt;
    logic          r_err_to;
    logic          r_err_ov;

    logic          w_tick;
    logic          w_sel_valid;
    logic [15:0]   w_sel_data;
    logic          w_capture;
    logic          w_timeout;
    logic          w_xfer;

    assign w_tick      = io_bus.run && (r_tick_cnt == TICK_LAST);
    assign w_sel_valid = r_sel ? io_bus.valid1 : io_bus.valid0;
    assign w_sel_data  = r_sel ? io_bus.data1  : io_bus.data0;
    // valid takes priority over a timeout landing in the same cycle
    assign w_capture   = (r_state == S_REQ) && io_bus.run && w_sel_valid;
    assign w_timeout   = (r_state == S_REQ) && io_bus.run && !w_sel_valid && (r_to_cnt == TO_LAST);
    assign w_xfer      = (r_state == S_OUT) && io_bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (!io_bus.run || r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_REQ) begin
            r_to_cnt <= r_to_cnt + OW'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sel        <= 1'b0;
            r_rr         <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.run) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!io_bus.run) begin
                        r_state <= S_IDLE;
                    end else if (w_tick && io_bus.mode != 2'b11) begin
                        r_state <= S_REQ;
                        r_sel   <= (io_bus.mode == 2'b10) ? r_rr : io_bus.mode[0];
                    end
                end
                S_REQ: begin
                    if (!io_bus.run) begin
                        r_state <= S_IDLE;
                    end else if (w_capture) begin
                        r_state    <= S_OUT;
                        r_out_data <= w_sel_data;
                        r_out_src  <= r_sel;
                    end else if (w_timeout) begin
                        r_state <= S_WAIT;
                        r_rr    <= ~r_rr;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        r_state      <= io_bus.run ? S_WAIT : S_IDLE;
                        r_rr         <= ~r_rr;
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // set beats clear when both land in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_to <= 1'b0;
            r_err_ov <= 1'b0;
        end else begin
            if (w_timeout)            r_err_to <= 1'b1;
            else if (io_bus.err_clr)  r_err_to <= 1'b0;
            if (w_tick && (r_state == S_REQ || r_state == S_OUT)) r_err_ov <= 1'b1;
            else if (io_bus.err_clr)  r_err_ov <= 1'b0;
        end
    end

    assign io_bus.en0         = (r_state == S_REQ) && !r_sel;
    assign io_bus.en1         = (r_state == S_REQ) && r_sel;
    assign io_bus.out_valid   = (r_state == S_OUT);
    assign io_bus.out_data    = r_out_data;
    assign io_bus.out_src     = r_out_src;
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.sample_cnt  = r_sample_cnt;
    assign io_bus.err_timeout = r_err_to;
    assign io_bus.err_overrun = r_err_ov;
endmodule

// File: tb/tb_gen_scheduler.sv
// Directed scenarios for gen_scheduler (TICK_DIV=4, TIMEOUT=3) with a queue scoreboard on the output port.
module tb_gen_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gen_scheduler_if sif ();
    gen_scheduler #(.TICK_DIV(4), .TIMEOUT(3)) dut (.clk(clk), .rst(rst), .io_bus(sif));

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] exp_q[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int dly0 = 0;
    int dly1 = 0;

    int run0 = 0, run1 = 0, last0 = 0, last1 = 0, en1_total = 0, en_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // src0 model: asserts valid dly0 cycles after en0 rises, with the next queued value
    initial begin
        int cnt = 0;
        sif.valid0 = 1'b0;
        sif.data0  = 16'h0;
        forever begin
            @(negedge clk);
            cnt = sif.en0 ? cnt + 1 : 0;
            if (sif.en0 && cnt == dly0 + 1 && q0.size() > 0) begin
                sif.valid0 = 1'b1;
                sif.data0  = q0.pop_front();
            end else begin
                sif.valid0 = 1'b0;
            end
        end
    end

    initial begin
        int cnt = 0;
        sif.valid1 = 1'b0;
        sif.data1  = 16'h0;
        forever begin
            @(negedge clk);
            cnt = sif.en1 ? cnt + 1 : 0;
            if (sif.en1 && cnt == dly1 + 1 && q1.size() > 0) begin
                sif.valid1 = 1'b1;
                sif.data1  = q1.pop_front();
            end else begin
                sif.valid1 = 1'b0;
            end
        end
    end

    // enable activity monitor: length of the last en pulse per source, totals
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                run0 = 0; run1 = 0; last0 = 0; last1 = 0; en1_total = 0; en_total = 0;
            end else begin
                if (sif.en0) run0++;
                else if (run0 > 0) begin last0 = run0; run0 = 0; end
                if (sif.en1) begin run1++; en1_total++; end
                else if (run1 > 0) begin last1 = run1; run1 = 0; end
                if (sif.en0 || sif.en1) en_total++;
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst && sif.out_valid && sif.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got src=%0d data=%h expected no transfer",
                             sif.out_src, sif.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({sif.out_src, sif.out_data} !== e) begin
                        n_err++;
                        $display("FAIL output: got src=%0d data=%h expected src=%0d data=%h",
                                 sif.out_src, sif.out_data, e[16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        sif.run = 1'b0; sif.mode = 2'b00; sif.err_clr = 1'b0; sif.out_ready = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete();
        dly0 = 0; dly1 = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", {sif.en0, sif.en1, sif.out_valid, sif.out_src, sif.busy,
                            sif.err_timeout, sif.err_overrun}, 32'h0);
        check("rst_cnt_data", {sif.sample_cnt, sif.out_data}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_err++; n_cmp++;
            $display("FAIL %s: timeout with %0d outputs pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
        n = 0;
    end

    initial begin
        int n;
        // mode 00, src0 answers two cycles after en0
        do_reset();
        q0.push_back(16'h0005); dly0 = 2;
        exp_q.push_back({1'b0, 16'h0005});
        sif.mode = 2'b00; sif.run = 1'b1;
        wait_drain(40, "m00_drain");
        wait_cycle(); sif.run = 1'b0;
        wait_cycle();
        check("m00_en0_len", last0, 3);
        check("m00_en1_never", en1_total, 0);
        check("m00_sample_cnt", sif.sample_cnt, 1);

        // round-robin over four ticks
        do_reset();
        q0.push_back(16'h0010); q0.push_back(16'h0011);
        q1.push_back(16'hABCD); q1.push_back(16'hABCE);
        dly0 = 1; dly1 = 1;
        exp_q.push_back({1'b0, 16'h0010}); exp_q.push_back({1'b1, 16'hABCD});
        exp_q.push_back({1'b0, 16'h0011}); exp_q.push_back({1'b1, 16'hABCE});
        sif.mode = 2'b10; sif.run = 1'b1;
        wait_drain(80, "rr_drain");
        wait_cycle(); sif.run = 1'b0;
        wait_cycle(); wait_cycle();
        check("rr_sample_cnt", sif.sample_cnt, 4);
        check("rr_no_errors", {sif.err_timeout, sif.err_overrun}, 0);
        check("rr_idle", sif.busy, 0);

        // mode 01 with silent src1: timeout, retry, clear
        do_reset();
        sif.mode = 2'b01; sif.run = 1'b1;
        n = 0;
        while (!sif.err_timeout && n < 40) begin @(negedge clk); #1; n++; end
        check("to_flag_set", sif.err_timeout, 1);
        check("to_en1_len", last1, 3);
        n = 0;
        while (!sif.en1 && n < 10) begin @(negedge clk); #1; n++; end
        check("to_retry_en1", sif.en1, 1);
        wait_cycle(); sif.run = 1'b0;
        wait_cycle();
        check("to_flag_held", sif.err_timeout, 1);
        sif.err_clr = 1'b1;
        wait_cycle(); sif.err_clr = 1'b0;
        @(negedge clk);
        check("to_flag_cleared", sif.err_timeout, 0);
        check("to_idle", sif.busy, 0);

        // backpressure: out_ready low for 10 cycles
        do_reset();
        q0.push_back(16'h1234);
        exp_q.push_back({1'b0, 16'h1234});
        sif.out_ready = 1'b0; sif.mode = 2'b00; sif.run = 1'b1;
        n = 0;
        while (!sif.out_valid && n < 30) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {sif.out_valid, sif.out_src, sif.out_data}, {1'b1, 1'b0, 16'h1234});
            @(negedge clk); #1;
        end
        check("bp_overrun", sif.err_overrun, 1);
        check("bp_cnt_before", sif.sample_cnt, 0);
        wait_cycle(); sif.out_ready = 1'b1;
        wait_drain(10, "bp_drain");
        wait_cycle(); sif.run = 1'b0;
        wait_cycle();
        check("bp_cnt_after", sif.sample_cnt, 1);

        // run dropped during REQ
        do_reset();
        sif.mode = 2'b00; sif.run = 1'b1;
        n = 0;
        while (!sif.en0 && n < 20) begin @(negedge clk); #1; n++; end
        check("drop_en0_high", sif.en0, 1);
        wait_cycle(); sif.run = 1'b0;
        @(negedge clk);
        check("drop_en0_last", sif.en0, 1);
        @(negedge clk);
        check("drop_en0_low", sif.en0, 0);
        check("drop_idle", sif.busy, 0);
        check("drop_no_err", {sif.err_timeout, sif.err_overrun}, 0);

        // async reset while in OUT
        do_reset();
        q0.push_back(16'h0055); q0.push_back(16'h0077);
        exp_q.push_back({1'b0, 16'h0055});
        sif.mode = 2'b00; sif.run = 1'b1;
        wait_drain(20, "ar_drain");
        wait_cycle(); sif.out_ready = 1'b0;
        n = 0;
        while (!sif.out_valid && n < 20) begin @(negedge clk); #1; n++; end
        repeat (3) @(negedge clk);
        #1;
        check("ar_pre_state", {sif.out_valid, sif.err_overrun}, 2'b11);
        check("ar_pre_cnt", sif.sample_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_outputs", {sif.out_valid, sif.en0, sif.en1, sif.err_timeout, sif.err_overrun}, 0);
        check("ar_cnt", sif.sample_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; sif.mode = 2'b11; sif.out_ready = 1'b1;
        repeat (14) wait_cycle();
        @(negedge clk);
        check("hold_no_en", en_total, 0);
        check("hold_busy", sif.busy, 1);
        sif.run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gen_scheduler.md
Name: gen_scheduler

Overview:
Sequencing controller for the two 16-bit value generators: src0 is the timer, src1 is a second generator with the same en/valid/data interface. It paces requests with a programmable sample tick, selects the source per mode (fixed or round-robin), and captures the returned value. It then forwards the value to the downstream consumer over a valid/ready handshake tagged with its source. It also detects generator timeouts and missed ticks.

Parameters:
TICK_DIV, 5000000, clk cycles per sample slot (tick period); legal values are 2 or more.
TIMEOUT, 15, max cycles en may stay high without a valid before the request is aborted; legal values are 1 or more.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = scheduling active
mode  in  2  00 src0 only, 01 src1 only, 10 round-robin, 11 hold (no requests)
err_clr  in  1  one-cycle pulse; clears sticky error flags
en0  out  1  request/enable to src0 (timer)
valid0  in  1  src0 value valid
data0  in  16  src0 value
en1  out  1  request/enable to src1
valid1  in  1  src1 value valid
data1  in  16  src1 value
out_valid  out  1  captured value available downstream
out_ready  in  1  downstream accepts
out_data  out  16  captured value
out_src  out  1  source of out_data (0/1)
busy  out  1  1 in any state except IDLE
sample_cnt  out  16  completed output transfers, wraps modulo 2^16
err_timeout  out  1  sticky; a request timed out
err_overrun  out  1  sticky; a tick arrived while in REQ or OUT

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, tick counter = 0, timeout counter = 0, rr pointer = src0.
- Tick counter:
  - Counts 0..TICK_DIV-1 while run=1 and wraps. It is held at 0 while run=0.
  - tick = 1 for one cycle when the counter equals TICK_DIV-1.
- FSM states: IDLE, WAIT_TICK, REQ, OUT.
- IDLE: en0 = en1 = 0. Moves to WAIT_TICK when run=1.
- WAIT_TICK:
  - On tick, mode is sampled.
  - 00 selects src0, 01 selects src1, 10 selects the rr pointer. Any of these goes to REQ.
  - 11 stays in WAIT_TICK.
  - mode is sampled only at the tick.
- REQ:
  - en of the selected source is held at 1; the other en stays 0. The timeout counter increments each cycle.
  - If the selected valid=1: data is captured into out_data and the source into out_src. en drops in the next cycle, the FSM goes to OUT, and out_valid rises in that same next cycle (1-cycle capture latency).
  - The valid of the non-selected source is ignored.
  - Timeout: if the counter reaches TIMEOUT with no valid, err_timeout is set, en drops, rr advances, and the FSM returns to WAIT_TICK. No output is produced.
- OUT:
  - out_valid = 1. out_data and out_src stay stable until out_valid && out_ready.
  - On the transfer: sample_cnt increments, rr toggles (only meaningful in mode 10), and out_valid drops the next cycle.
  - Next state is WAIT_TICK if run=1, otherwise IDLE.
- run deassertion:
  - In WAIT_TICK or REQ, the FSM goes to IDLE on the next cycle and en drops. No capture and no error are recorded.
  - In OUT, the handshake completes first, then the FSM goes to IDLE.
- tick while in REQ or OUT: the tick is dropped (not queued) and err_overrun is set.
- Sticky flags:
  - err_clr clears both flags.
  - If err_clr and a set event occur in the same cycle, the set wins.
- valid coincident with the timeout cycle: valid wins; the value is captured and no error is raised.
- sample_cnt wraps from 0xFFFF to 0x0000. All other counters are internal only.
- Reset mid-operation aborts immediately: en0, en1 and out_valid go to 0 asynchronously.

Test Plan:
All tests use TICK_DIV=4 and TIMEOUT=3.
- Mode 00, run=1; src0 model answers valid0 two cycles after en0 with 0x0005; out_ready=1.
  -> en0 high 3 cycles; out_valid 1 cycle with out_data=0x0005, out_src=0; sample_cnt=1; en1 never high.
- Mode 10 for 4 ticks; src0 returns 0x0010, 0x0011 and src1 returns 0xABCD, 0xABCE.
  -> outputs in order (0,0x0010), (1,0xABCD), (0,0x0011), (1,0xABCE); sample_cnt=4.
- Mode 01 with src1 silent.
  -> en1 high exactly 3 cycles then low; err_timeout=1; no out_valid.
  -> next tick retries src1; err_clr pulse clears err_timeout.
- out_ready=0 for 10 cycles after capture of 0x1234.
  -> out_valid/out_data=0x1234 stay stable; err_overrun=1 after the missed tick.
  -> after out_ready=1, one transfer, sample_cnt +1.
- run dropped while in REQ.
  -> en0 falls next cycle, FSM to IDLE, busy=0, no output.
- Async rst asserted while in OUT.
  -> out_valid, en0/en1, sample_cnt and err flags all 0 immediately; mode 11 afterwards gives no en activity across 3 ticks.
